// File: rtl/pwi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwi_pkg : shared types and sizing for pulse_window_integrator            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pwi_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DLY_W_DEF  = 8;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    INTEG = 2'd2,
    DONE  = 2'd3
  } pwi_state_e;

  // One extra bit per bit of window length keeps the sum exact for any length.
  function automatic int pwi_sum_w(input int data_w, input int len_w);
    return data_w + len_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trig_edge_sync : two-flop trigger pipeline with rising-edge output       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module trig_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic edge_o
);

  // Kept as discrete flops so the edge timing matches the IIR-side copy.
  (* shreg_extract = "no", equivalent_register_removal = "no" *)
  logic trig_a_q;
  (* shreg_extract = "no", equivalent_register_removal = "no" *)
  logic trig_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_a_q <= 1'b0;
      trig_b_q <= 1'b0;
    end else begin
      trig_a_q <= trig_i;
      trig_b_q <= trig_a_q;
    end
  end

  assign edge_o = trig_a_q & ~trig_b_q;

endmodule
`default_nettype wire

// File: rtl/pulse_window_integrator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_window_integrator : delayed, fixed-length signed sample integrator |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pulse_window_integrator
  import pwi_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DLY_W  = DLY_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int SUM_W  = pwi_sum_w(DATA_W, LEN_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [DATA_W-1:0] din,
  input  logic              oflow_in,
  input  logic [DLY_W-1:0]  win_delay,
  input  logic [LEN_W-1:0]  win_len,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid,
  output logic              sum_oflow,
  output logic              busy,
  output logic              trig_missed
);

  localparam int                CNT_W   = (DLY_W > LEN_W) ? DLY_W : LEN_W;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  pwi_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;
  logic [SUM_W-1:0]   acc_q;
  logic               oflow_acc_q;
  logic [SUM_W-1:0]   sum_q;
  logic               sum_valid_q;
  logic               sum_oflow_q;
  logic               trig_missed_q;

  logic               trig_edge;
  logic [SUM_W-1:0]   din_ext;

  trig_edge_sync u_trig_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .trig_i (trig),
    .edge_o (trig_edge)
  );

  assign din_ext = {{(SUM_W-DATA_W){din[DATA_W-1]}}, din};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      len_q         <= '0;
      acc_q         <= '0;
      oflow_acc_q   <= 1'b0;
      sum_q         <= '0;
      sum_valid_q   <= 1'b0;
      sum_oflow_q   <= 1'b0;
      trig_missed_q <= 1'b0;
    end else begin
      sum_valid_q   <= 1'b0;
      trig_missed_q <= trig_edge && (state_q != IDLE);

      case (state_q)
        IDLE: begin
          if (trig_edge) begin
            acc_q       <= '0;
            oflow_acc_q <= 1'b0;
            len_q       <= win_len;
            if (win_delay != '0) begin
              state_q <= DELAY;
              cnt_q   <= CNT_W'(win_delay);
            end else if (win_len != '0) begin
              state_q <= INTEG;
              cnt_q   <= CNT_W'(win_len);
            end else begin
              state_q <= DONE;
            end
          end
        end

        DELAY: begin
          if (cnt_q == CNT_ONE) begin
            if (len_q != '0) begin
              state_q <= INTEG;
              cnt_q   <= CNT_W'(len_q);
            end else begin
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        INTEG: begin
          acc_q       <= acc_q + din_ext;
          oflow_acc_q <= oflow_acc_q | oflow_in;
          if (cnt_q == CNT_ONE) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        DONE: begin
          sum_q       <= acc_q;
          sum_oflow_q <= oflow_acc_q;
          sum_valid_q <= 1'b1;
          state_q     <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign sum_out     = sum_q;
  assign sum_valid   = sum_valid_q;
  assign sum_oflow   = sum_oflow_q;
  assign trig_missed = trig_missed_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire
